ahb_arbiter_nm: RTL and testbench
=================================

AHB_ARBITER_NM -- requirements
Module: ahb_arbiter_nm

Interface
REQ-001 Parameter P_NUMM, default 4, number of masters, legal 2..15.
REQ-002 Parameter P_MODE, default 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-003 Parameter P_DEFAULT_MST, default 0, master granted when no unmasked request exists.
REQ-004 HCLK  in  1  bus clock; all state changes on rising edge.
REQ-005 HRESETn  in  1  reset, asynchronous, active-low.
REQ-006 HBUSREQ  in  P_NUMM  per-master bus request.
REQ-007 HLOCK  in  P_NUMM  per-master locked-transfer request.
REQ-008 HTRANS  in  2  muxed transfer type of current address-phase owner.
REQ-009 HBURST  in  3  muxed burst type of current address-phase owner.
REQ-010 HREADY  in  1  muxed slave ready.
REQ-011 HRESP  in  2  muxed slave response.
REQ-012 HSPLIT  in  16  OR of all slave HSPLIT vectors; bit i releases master i.
REQ-013 HGRANT  out  P_NUMM  one-hot grant, registered; all-zero only when dummy master owns bus.
REQ-014 HMASTER  out  4  address-phase owner index; value 15 = dummy master.
REQ-015 HMASTLOCK  out  1  current address phase is locked.

Function
REQ-016 HGRANT SHALL change only on an HCLK edge where HREADY=1 and an arbitration point holds.
REQ-017 Arbitration point: HTRANS=IDLE; or HTRANS=NONSEQ with HBURST SINGLE; or HTRANS in {NONSEQ,SEQ} with HBURST INCR and owner's HBUSREQ=0; or SEQ accepted with beats_left=1 for fixed bursts.
REQ-018 beats_left SHALL load 3/7/15 on accepted NONSEQ with INCR4|WRAP4 / INCR8|WRAP8 / INCR16|WRAP16, decrement on each accepted SEQ, and clear on accepted IDLE or NONSEQ outside a burst.
REQ-019 Accepted = HREADY=1 on the edge; BUSY never decrements beats_left and is never an arbitration point.
REQ-020 Early termination: ERROR/RETRY/SPLIT response SHALL clear beats_left and force an arbitration point on the next HREADY=1 edge.
REQ-021 Lock: if granted master has HLOCK=1 at an arbitration point, HGRANT SHALL be held regardless of other requests.
REQ-022 HMASTER and HMASTLOCK SHALL update from registered HGRANT index and HLOCK on the next HREADY=1 edge after HGRANT changes (one address-phase delay).
REQ-023 Fixed mode: grant lowest-index unmasked requester.
REQ-024 Round-robin mode: search unmasked requesters from (last granted index + 1) mod P_NUMM upward with wrap; last granted updates only when a real requester wins.
REQ-025 No unmasked requester: grant P_DEFAULT_MST if unmasked, else HGRANT=0 and HMASTER=15 (dummy; arbiter treats HTRANS as IDLE).
REQ-026 SPLIT mask: first cycle of HRESP=SPLIT with HREADY=0 SHALL set mask bit HMASTER; HSPLIT[i]=1 clears mask bit i next edge; simultaneous set/clear of same bit -> clear wins.
REQ-027 Masked masters SHALL never be granted; a masked master's HBUSREQ is ignored.
REQ-028 HSPLIT bits >= P_NUMM SHALL be ignored.

Reset
REQ-029 On HRESETn=0 (asynchronous): HGRANT = one-hot P_DEFAULT_MST, HMASTER = P_DEFAULT_MST, HMASTLOCK=0, mask=0, beats_left=0, round-robin pointer = P_DEFAULT_MST.
REQ-030 Reset mid-burst SHALL abandon the burst; first post-reset edge arbitrates normally.

Structure
REQ-031 Shared package ahb_pkg SHALL hold HTRANS, HBURST, HRESP enums, the dummy-master constant 15, and a burst-length function.
REQ-032 One sub-module ahb_arb_picker SHALL implement the combinational rotating-base priority select (request, mask, base, mode -> one-hot, valid).

Verification
REQ-033 P_NUMM=4, RR, HBUSREQ=4'b1111, SINGLE NONSEQ every cycle -> grants 1,2,3,0,1 on consecutive arbitration edges.
REQ-034 Fixed mode, M2 INCR4 at 0x400, M0 requests at beat 2 -> HGRANT stays M2 until 4th beat accepted, then M0; HMASTER=0 one HREADY edge later.
REQ-035 M1 HLOCK=1 INCR, M0 and M3 requesting -> HGRANT held on M1 until HLOCK=0; HMASTLOCK=1 throughout.
REQ-036 M1 address phase gets SPLIT (2 cycles) -> mask[1]=1, M1 not granted despite HBUSREQ; HSPLIT=16'h0002 -> M1 granted at next arbitration point.
REQ-037 All requesters masked and P_DEFAULT_MST masked -> HGRANT=0, HMASTER=15; HRESETn low mid-INCR8 -> outputs at REQ-029 values within same cycle.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB encodings and helpers for the arbiter slice.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    localparam int unsigned MST_W     = 4;
    localparam int unsigned BEATS_W   = 4;
    localparam logic [3:0]  DUMMY_MST = 4'd15;

    // Beats in a fixed-length burst; 1 for SINGLE, 0 for undefined-length INCR.
    function automatic logic [4:0] burst_len(input logic [2:0] burst);
        logic [4:0] len;
        case (hburst_t'(burst))
            HBURST_SINGLE:                len = 5'd1;
            HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
            HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
            default:                      len = 5'd0;
        endcase
        return len;
    endfunction

    // Index of the lowest set bit, or the dummy master index when none is set.
    function automatic logic [3:0] onehot_idx(input logic [15:0] vec);
        logic [3:0] idx;
        idx = DUMMY_MST;
        for (int i = 15; i >= 0; i--) begin
            if (vec[4'(i)]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arb_picker.sv
// Rotating-base priority select over unmasked requesters.
module ahb_arb_picker
    import ahb_pkg::*;
#(
    parameter int unsigned P_NUMM = 4
) (
    input  logic [P_NUMM-1:0] req,
    input  logic [P_NUMM-1:0] mask,
    input  logic [3:0]        base,
    input  logic              mode,
    output logic [P_NUMM-1:0] pick_c,
    output logic              valid_c
);

    localparam int unsigned IDX_W = (P_NUMM > 1) ? $clog2(P_NUMM) : 1;

    logic [P_NUMM-1:0] eligible;
    int unsigned       start;
    int unsigned       idx;

    assign eligible = req & ~mask;

    // Walk eligible requesters from the start index upward with wrap; first hit wins.
    always_comb begin
        pick_c  = '0;
        valid_c = 1'b0;
        start   = mode ? 32'(base) : 32'd0;
        idx     = 32'd0;
        for (int unsigned i = 0; i < P_NUMM; i++) begin
            idx = start + i;
            if (idx >= P_NUMM) begin
                idx = idx - P_NUMM;
            end
            if (!valid_c && eligible[IDX_W'(idx)]) begin
                pick_c[IDX_W'(idx)] = 1'b1;
                valid_c             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_nm.sv
// AHB bus arbiter: fixed or round-robin, burst/lock aware, SPLIT masking.
module ahb_arbiter_nm
    import ahb_pkg::*;
#(
    parameter int unsigned P_NUMM        = 4,
    parameter int unsigned P_MODE        = 1,
    parameter int unsigned P_DEFAULT_MST = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [P_NUMM-1:0] HBUSREQ,
    input  logic [P_NUMM-1:0] HLOCK,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HBURST,
    input  logic              HREADY,
    input  logic [1:0]        HRESP,
    input  logic [15:0]       HSPLIT,
    output logic [P_NUMM-1:0] HGRANT,
    output logic [3:0]        HMASTER,
    output logic              HMASTLOCK
);

    localparam int unsigned       IDX_W      = (P_NUMM > 1) ? $clog2(P_NUMM) : 1;
    localparam logic [P_NUMM-1:0] DEF_ONEHOT = {{(P_NUMM-1){1'b0}}, 1'b1} << P_DEFAULT_MST;

    logic [P_NUMM-1:0]  mask;
    logic [BEATS_W-1:0] beats_left;
    logic [MST_W-1:0]   rr_ptr;
    logic               early_q;
    logic               split_q;

    logic               owner_valid;
    logic [IDX_W-1:0]   own_idx;
    htrans_t            trans;
    hburst_t            burst;
    logic               fixed_burst;
    logic               resp_err;
    logic               resp_split;
    logic               arb_pt_c;

    logic [MST_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               lock_hold;
    logic               owner_lock;

    logic [MST_W-1:0]   base;
    logic [P_NUMM-1:0]  pick;
    logic               pick_valid;
    logic [MST_W-1:0]   pick_idx;

    logic [P_NUMM-1:0]  grant_nxt;
    logic [MST_W-1:0]   rr_nxt;
    logic [BEATS_W-1:0] beats_nxt;
    logic [P_NUMM-1:0]  split_set_vec;
    logic [P_NUMM-1:0]  mask_nxt;
    logic               hsplit_unused;

    assign hsplit_unused = ^HSPLIT[15:P_NUMM];

    // Decode the current address phase and decide whether this edge is an arbitration point.
    always_comb begin
        owner_valid = (32'(HMASTER) < P_NUMM);
        own_idx     = IDX_W'(HMASTER);
        trans       = owner_valid ? htrans_t'(HTRANS) : HTRANS_IDLE;
        burst       = hburst_t'(HBURST);
        fixed_burst = (burst_len(HBURST) > 5'd1);
        resp_err    = (hresp_t'(HRESP) != HRESP_OKAY);
        resp_split  = (hresp_t'(HRESP) == HRESP_SPLIT);
        arb_pt_c    = HREADY && (early_q || resp_err
                      || (trans == HTRANS_IDLE)
                      || (trans == HTRANS_NONSEQ && burst == HBURST_SINGLE)
                      || ((trans == HTRANS_NONSEQ || trans == HTRANS_SEQ)
                          && burst == HBURST_INCR && !HBUSREQ[own_idx])
                      || (trans == HTRANS_SEQ && fixed_burst && beats_left == 4'd1));
    end

    // Current grant holder and whether its lock pins the bus.
    always_comb begin
        grant_idx   = onehot_idx(16'(HGRANT));
        grant_valid = |HGRANT;
        owner_lock  = grant_valid && HLOCK[IDX_W'(grant_idx)];
        lock_hold   = owner_lock && !mask[IDX_W'(grant_idx)];
        base        = (32'(rr_ptr) + 32'd1 >= P_NUMM) ? 4'd0 : rr_ptr + 4'd1;
        pick_idx    = onehot_idx(16'(pick));
    end

    ahb_arb_picker #(
        .P_NUMM (P_NUMM)
    ) u_picker (
        .req     (HBUSREQ),
        .mask    (mask),
        .base    (base),
        .mode    (P_MODE == 1),
        .pick_c  (pick),
        .valid_c (pick_valid)
    );

    // Next grant: hold unless arbitrating; winner, else default master, else dummy.
    always_comb begin
        grant_nxt = HGRANT;
        rr_nxt    = rr_ptr;
        if (arb_pt_c && !lock_hold) begin
            if (pick_valid) begin
                grant_nxt = pick;
                rr_nxt    = pick_idx;
            end else if (!mask[IDX_W'(P_DEFAULT_MST)]) begin
                grant_nxt = DEF_ONEHOT;
            end else begin
                grant_nxt = '0;
            end
        end
    end

    // Beat counter for fixed-length bursts; error responses abandon the burst.
    always_comb begin
        beats_nxt = beats_left;
        if (resp_err) begin
            beats_nxt = '0;
        end else if (HREADY) begin
            case (trans)
                HTRANS_IDLE:   beats_nxt = '0;
                HTRANS_NONSEQ: beats_nxt = fixed_burst ? BEATS_W'(burst_len(HBURST) - 5'd1) : '0;
                HTRANS_SEQ:    beats_nxt = (beats_left != '0) ? beats_left - 4'd1 : '0;
                default:       beats_nxt = beats_left;
            endcase
        end
    end

    // SPLIT mask: set on the first SPLIT wait cycle, release via HSPLIT (release wins).
    always_comb begin
        split_set_vec = '0;
        if (resp_split && !HREADY && !split_q && owner_valid) begin
            split_set_vec[own_idx] = 1'b1;
        end
        mask_nxt = (mask | split_set_vec) & ~HSPLIT[P_NUMM-1:0];
    end

    // State and registered outputs; HMASTER/HMASTLOCK follow the grant one address phase later.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HGRANT     <= DEF_ONEHOT;
            HMASTER    <= 4'(P_DEFAULT_MST);
            HMASTLOCK  <= 1'b0;
            mask       <= '0;
            beats_left <= '0;
            rr_ptr     <= 4'(P_DEFAULT_MST);
            early_q    <= 1'b0;
            split_q    <= 1'b0;
        end else begin
            HGRANT     <= grant_nxt;
            rr_ptr     <= rr_nxt;
            mask       <= mask_nxt;
            beats_left <= beats_nxt;
            early_q    <= HREADY ? 1'b0 : (early_q | resp_err);
            split_q    <= resp_split && !HREADY;
            if (HREADY) begin
                HMASTER   <= grant_idx;
                HMASTLOCK <= owner_lock;
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_nm.sv
// Directed bench: one round-robin and one fixed-priority arbiter on shared stimulus.
module tb_ahb_arbiter_nm;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic [3:0]  HBUSREQ = '0;
    logic [3:0]  HLOCK   = '0;
    logic [1:0]  HTRANS  = 2'b00;
    logic [2:0]  HBURST  = 3'b000;
    logic        HREADY  = 1'b1;
    logic [1:0]  HRESP   = 2'b00;
    logic [15:0] HSPLIT  = '0;

    logic [3:0]  g_rr, g_fix;
    logic [3:0]  m_rr, m_fix;
    logic        l_rr, l_fix;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000, B_INCR = 3'b001, B_INCR4 = 3'b011, B_INCR8 = 3'b101;
    localparam logic [1:0] R_OKAY = 2'b00, R_SPLIT = 2'b11;

    ahb_arbiter_nm #(.P_NUMM(4), .P_MODE(1), .P_DEFAULT_MST(0)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
        .HSPLIT(HSPLIT), .HGRANT(g_rr), .HMASTER(m_rr), .HMASTLOCK(l_rr)
    );

    ahb_arbiter_nm #(.P_NUMM(4), .P_MODE(0), .P_DEFAULT_MST(0)) u_fix (
        .HCLK(HCLK), .HRESETn(HRESETn), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
        .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY), .HRESP(HRESP),
        .HSPLIT(HSPLIT), .HGRANT(g_fix), .HMASTER(m_fix), .HMASTLOCK(l_fix)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; values must appear without a clock edge.
    task automatic do_reset(input string tag);
        #2;
        HBUSREQ = '0; HLOCK = '0; HTRANS = T_IDLE; HBURST = B_SINGLE;
        HREADY = 1'b1; HRESP = R_OKAY; HSPLIT = '0;
        HRESETn = 1'b0;
        #1;
        check({tag, "_grant_rr"},  16'(g_rr),  16'h0001);
        check({tag, "_master_rr"}, 16'(m_rr),  16'h0000);
        check({tag, "_lock_rr"},   16'(l_rr),  16'h0000);
        check({tag, "_grant_fix"}, 16'(g_fix), 16'h0001);
        check({tag, "_master_fix"},16'(m_fix), 16'h0000);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
    endtask

    logic [3:0] rr_grants  [5] = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
    logic [3:0] rr_masters [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};

    initial begin
        do_reset("rst0");

        // Round-robin rotation with all masters issuing SINGLE transfers.
        HBUSREQ = 4'b1111; HTRANS = T_NSEQ; HBURST = B_SINGLE;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_rotate_grant",  16'(g_rr), 16'(rr_grants[i]));
            check("rr_rotate_master", 16'(m_rr), 16'(rr_masters[i]));
            check("fix_lowest_grant", 16'(g_fix), 16'h0001);
        end

        // Fixed priority: M2 INCR4 not preempted by M0 until the 4th beat.
        do_reset("rst1");
        HBUSREQ = 4'b0100; HTRANS = T_IDLE;
        tick(); check("fix_grant_m2", 16'(g_fix), 16'h0004);
        tick(); check("fix_master_m2", 16'(m_fix), 16'h0002);
        HTRANS = T_NSEQ; HBURST = B_INCR4;
        tick(); check("fix_beat1", 16'(g_fix), 16'h0004);
        HTRANS = T_SEQ; HBUSREQ = 4'b0101;
        tick(); check("fix_beat2", 16'(g_fix), 16'h0004);
        HREADY = 1'b0;
        tick(); check("fix_wait", 16'(g_fix), 16'h0004);
        HREADY = 1'b1;
        tick(); check("fix_beat3", 16'(g_fix), 16'h0004);
        tick(); check("fix_beat4_grant", 16'(g_fix), 16'h0001);
        check("fix_beat4_master", 16'(m_fix), 16'h0002);
        HTRANS = T_IDLE;
        tick(); check("fix_handover_master", 16'(m_fix), 16'h0000);

        // Locked INCR by M1 holds the grant against M0/M3 until HLOCK drops.
        do_reset("rst2");
        HBUSREQ = 4'b0010; HLOCK = 4'b0010; HTRANS = T_IDLE;
        tick(); check("lock_grant_m1", 16'(g_rr), 16'h0002);
        tick(); check("lock_master", 16'(m_rr), 16'h0001);
        check("lock_mastlock", 16'(l_rr), 16'h0001);
        HBUSREQ = 4'b1011; HTRANS = T_NSEQ; HBURST = B_INCR;
        tick(); check("lock_incr_nseq", 16'(g_rr), 16'h0002);
        HTRANS = T_SEQ;
        tick(); check("lock_incr_seq", 16'(g_rr), 16'h0002);
        HBUSREQ = 4'b1001;
        tick(); check("lock_hold_grant", 16'(g_rr), 16'h0002);
        check("lock_hold_mastlock", 16'(l_rr), 16'h0001);
        HLOCK = 4'b0000; HTRANS = T_IDLE;
        tick(); check("lock_release_grant", 16'(g_rr), 16'h0008);
        check("lock_release_mastlock", 16'(l_rr), 16'h0000);

        // SPLIT masks M1 until HSPLIT bit 1; high HSPLIT bits are ignored.
        do_reset("rst3");
        HBUSREQ = 4'b0010; HTRANS = T_IDLE;
        tick();
        tick(); check("split_owner_m1", 16'(m_rr), 16'h0001);
        HBUSREQ = 4'b0011; HTRANS = T_NSEQ; HBURST = B_INCR;
        tick(); check("split_pre", 16'(g_rr), 16'h0002);
        HREADY = 1'b0; HRESP = R_SPLIT; HTRANS = T_IDLE;
        tick(); check("split_cycle1", 16'(g_rr), 16'h0002);
        HREADY = 1'b1;
        tick(); check("split_cycle2", 16'(g_rr), 16'h0001);
        HRESP = R_OKAY; HBUSREQ = 4'b0010; HSPLIT = 16'hFFF0;
        tick(); check("split_masked_m1", 16'(g_rr), 16'h0001);
        HSPLIT = 16'h0000;
        tick(); check("split_high_bits_ignored", 16'(g_rr), 16'h0001);
        HSPLIT = 16'h0002;
        tick();
        HSPLIT = 16'h0000;
        tick(); check("split_released_m1", 16'(g_rr), 16'h0002);

        // Everything masked including the default master: dummy owns the bus.
        do_reset("rst4");
        HBUSREQ = 4'b0001; HTRANS = T_NSEQ; HBURST = B_INCR;
        tick();
        HREADY = 1'b0; HRESP = R_SPLIT; HTRANS = T_IDLE;
        tick();
        HREADY = 1'b1;
        tick(); check("dummy_grant", 16'(g_rr), 16'h0000);
        HRESP = R_OKAY;
        tick(); check("dummy_master", 16'(m_rr), 16'h000F);
        check("dummy_grant_hold", 16'(g_rr), 16'h0000);
        check("dummy_mastlock", 16'(l_rr), 16'h0000);
        HTRANS = T_NSEQ; HBURST = B_INCR; HSPLIT = 16'h0001;
        tick();
        HSPLIT = 16'h0000;
        tick(); check("dummy_exit_grant", 16'(g_rr), 16'h0001);

        // Reset in the middle of an INCR8 abandons the burst.
        do_reset("rst5");
        HBUSREQ = 4'b0100; HTRANS = T_IDLE;
        tick();
        tick();
        HTRANS = T_NSEQ; HBURST = B_INCR8;
        tick();
        HTRANS = T_SEQ;
        tick(); check("incr8_mid_grant", 16'(g_fix), 16'h0004);
        do_reset("rst_mid_burst");
        HBUSREQ = 4'b0100; HTRANS = T_IDLE;
        tick(); check("post_reset_arb", 16'(g_fix), 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
